// File: rtl/tpu_pkg.sv
// Shared types and width helpers for the TPU tile sequencer.
// Widths are derived from the block parameters so the top can be re-parameterised.
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam int unsigned DEF_ARRAY_SIZE    = 8;
  localparam int unsigned DEF_K_ACCUM_DEPTH = 24;
  localparam int unsigned DEF_NUM_BANKS     = 3;
  localparam int unsigned DEF_MAX_DATA_SET  = 4;

  // $clog2 that never returns 0, so single-value fields still get one bit
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned cycle_w(input int unsigned k_depth, input int unsigned array_size);
    return clog2_min1(k_depth + 2 * array_size);
  endfunction

  function automatic int unsigned index_w(input int unsigned array_size);
    return clog2_min1(array_size);
  endfunction

  function automatic int unsigned set_w(input int unsigned max_data_set);
    return clog2_min1(max_data_set + 1);
  endfunction

  function automatic int unsigned kstep_w(input int unsigned k_depth);
    return clog2_min1(k_depth + 1);
  endfunction

  function automatic int unsigned bank_w(input int unsigned num_banks);
    return clog2_min1(num_banks);
  endfunction

  localparam int unsigned CYCLE_W = cycle_w(DEF_K_ACCUM_DEPTH, DEF_ARRAY_SIZE);
  localparam int unsigned INDEX_W = index_w(DEF_ARRAY_SIZE);
  localparam int unsigned SET_W   = set_w(DEF_MAX_DATA_SET);

endpackage

// File: rtl/tpu_tile_sequencer.sv
// Sequences clear/load/drain/write phases of a systolic tile for up to MAX_DATA_SET sets.
// Every output is a flop; next values are computed from the next-state counters.
module tpu_tile_sequencer
  import tpu_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE    = 8,
  parameter int unsigned K_ACCUM_DEPTH = 24,
  parameter int unsigned NUM_BANKS     = 3,
  parameter int unsigned MAX_DATA_SET  = 4,
  parameter int unsigned RADDR_WIDTH   = 10,
  parameter int unsigned WADDR_WIDTH   = 6
) (
  input  logic                                     clk,
  input  logic                                     srst,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic [set_w(MAX_DATA_SET)-1:0]           cfg_data_sets,
  input  logic [kstep_w(K_ACCUM_DEPTH)-1:0]        cfg_k_steps,
  input  logic                                     out_ready,
  output logic [RADDR_WIDTH-1:0]                   sram_raddr_w,
  output logic [RADDR_WIDTH-1:0]                   sram_raddr_d,
  output logic                                     alu_start,
  output logic [cycle_w(K_ACCUM_DEPTH, ARRAY_SIZE)-1:0] cycle_num,
  output logic [index_w(ARRAY_SIZE)-1:0]           matrix_index,
  output logic [NUM_BANKS-1:0]                     sram_write_enable,
  output logic [WADDR_WIDTH-1:0]                   sram_waddr,
  output logic                                     busy,
  output logic                                     done
);

  localparam int unsigned SW        = set_w(MAX_DATA_SET);
  localparam int unsigned KW        = kstep_w(K_ACCUM_DEPTH);
  localparam int unsigned CW        = cycle_w(K_ACCUM_DEPTH, ARRAY_SIZE);
  localparam int unsigned IW        = index_w(ARRAY_SIZE);
  localparam int unsigned BW        = bank_w(NUM_BANKS);
  localparam int unsigned DRAIN_LEN = 2 * ARRAY_SIZE - 1;

  state_e                 state_q, state_d;
  logic [SW-1:0]          set_q, set_d;
  logic [SW-1:0]          pass_q, pass_d;
  logic [BW-1:0]          bank_q, bank_d;
  logic [SW-1:0]          nsets_q, nsets_d;
  logic [KW-1:0]          k_q, k_d;
  logic [CW-1:0]          cyc_q, cyc_d;
  logic [IW-1:0]          row_q, row_d;
  logic [NUM_BANKS-1:0]   we_q, we_d;
  logic [RADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [WADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   alu_q, alu_d;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      set_q   <= '0;
      pass_q  <= '0;
      bank_q  <= '0;
      nsets_q <= '0;
      k_q     <= '0;
      cyc_q   <= '0;
      row_q   <= '0;
      we_q    <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      alu_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      pass_q  <= pass_d;
      bank_q  <= bank_d;
      nsets_q <= nsets_d;
      k_q     <= k_d;
      cyc_q   <= cyc_d;
      row_q   <= row_d;
      we_q    <= we_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      alu_q   <= alu_d;
    end
  end

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    pass_d  = pass_q;
    bank_d  = bank_q;
    nsets_d = nsets_q;
    k_d     = k_q;
    cyc_d   = cyc_q;
    row_d   = row_q;
    we_d    = '0;
    raddr_d = '0;
    waddr_d = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    alu_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          nsets_d = cfg_data_sets;
          k_d     = cfg_k_steps;
          set_d   = '0;
          pass_d  = '0;
          bank_d  = '0;
          cyc_d   = '0;
          row_d   = '0;
          state_d = (cfg_data_sets == '0) ? DONE : CLEAR;
        end
      end
      CLEAR: begin
        cyc_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        cyc_d = cyc_q + CW'(1);
        if (32'(cyc_q) + 32'd1 >= 32'(k_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (32'(cyc_q) + 32'd1 >= 32'(k_q) + DRAIN_LEN) begin
          cyc_d   = '0;
          row_d   = '0;
          state_d = WRITE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      WRITE: begin
        // A row completes at the end of a cycle that carried its strobe
        if (we_q != '0) begin
          if (row_q == IW'(ARRAY_SIZE - 1)) begin
            row_d = '0;
            if (32'(set_q) + 32'd1 >= 32'(nsets_q)) begin
              state_d = DONE;
            end else begin
              set_d   = set_q + SW'(1);
              state_d = CLEAR;
              if (bank_q == BW'(NUM_BANKS - 1)) begin
                bank_d = '0;
                pass_d = pass_q + SW'(1);
              end else begin
                bank_d = bank_q + BW'(1);
              end
            end
          end else begin
            row_d = row_q + IW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Cancel drops straight back to IDLE and forgets the captured run
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      set_d   = '0;
      pass_d  = '0;
      bank_d  = '0;
      nsets_d = '0;
      k_d     = '0;
      cyc_d   = '0;
      row_d   = '0;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    alu_d  = (state_d == LOAD) || (state_d == DRAIN);
    if (state_d == LOAD) begin
      raddr_d = RADDR_WIDTH'(32'(set_d) * K_ACCUM_DEPTH + 32'(cyc_d));
    end
    if (state_d == WRITE) begin
      waddr_d = WADDR_WIDTH'(32'(pass_d) * ARRAY_SIZE + 32'(row_d));
      if (out_ready) we_d[bank_d] = 1'b1;
    end
  end

  assign sram_raddr_w      = raddr_q;
  assign sram_raddr_d      = raddr_q;
  assign alu_start         = alu_q;
  assign cycle_num         = cyc_q;
  assign matrix_index      = row_q;
  assign sram_write_enable = we_q;
  assign sram_waddr        = waddr_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Self-checking bench: a per-run expected output trace is built from the phase rules,
// then replayed cycle by cycle against the sequencer.
module tb_tpu_tile_sequencer;

  localparam int A  = 8;
  localparam int K  = 24;
  localparam int NB = 3;
  localparam int MS = 4;
  localparam int NONE = -1;

  logic       clk = 1'b0;
  logic       srst, start, abort, out_ready;
  logic [2:0] cfg_data_sets;
  logic [4:0] cfg_k_steps;
  logic [9:0] sram_raddr_w, sram_raddr_d;
  logic       alu_start;
  logic [5:0] cycle_num;
  logic [2:0] matrix_index;
  logic [2:0] sram_write_enable;
  logic [5:0] sram_waddr;
  logic       busy, done;

  always #5 clk = ~clk;

  tpu_tile_sequencer #(
    .ARRAY_SIZE(A), .K_ACCUM_DEPTH(K), .NUM_BANKS(NB), .MAX_DATA_SET(MS),
    .RADDR_WIDTH(10), .WADDR_WIDTH(6)
  ) dut (
    .clk(clk), .srst(srst), .start(start), .abort(abort),
    .cfg_data_sets(cfg_data_sets), .cfg_k_steps(cfg_k_steps), .out_ready(out_ready),
    .sram_raddr_w(sram_raddr_w), .sram_raddr_d(sram_raddr_d), .alu_start(alu_start),
    .cycle_num(cycle_num), .matrix_index(matrix_index),
    .sram_write_enable(sram_write_enable), .sram_waddr(sram_waddr),
    .busy(busy), .done(done)
  );

  typedef struct {
    int busy; int done; int alu; int cyc; int raddr; int midx; int we; int waddr;
  } rec_t;

  rec_t exp_q[$];
  bit   rdy[0:1023];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic rec_t idle_rec();
    rec_t r;
    r.busy = 0; r.done = 0; r.alu = 0; r.cyc = 0;
    r.raddr = 0; r.midx = 0; r.we = 0; r.waddr = 0;
    return r;
  endfunction

  task automatic check(input string tag, input int step, input logic [31:0] obs, input int expv);
    vectors++;
    assert (obs === 32'(expv)) else begin
      miscompares++;
      $error("FAIL %s step %0d: observed %0d expected %0d", tag, step, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag, input int step, input rec_t r);
    check({tag, ".busy"},   step, 32'(busy), r.busy);
    check({tag, ".done"},   step, 32'(done), r.done);
    check({tag, ".alu"},    step, 32'(alu_start), r.alu);
    check({tag, ".cycle"},  step, 32'(cycle_num), r.cyc);
    check({tag, ".raddrw"}, step, 32'(sram_raddr_w), r.raddr);
    check({tag, ".raddrd"}, step, 32'(sram_raddr_d), r.raddr);
    check({tag, ".midx"},   step, 32'(matrix_index), r.midx);
    check({tag, ".we"},     step, 32'(sram_write_enable), r.we);
    check({tag, ".waddr"},  step, 32'(sram_waddr), r.waddr);
  endtask

  // mode 0: always ready, 1: random ~75% ready, 2: ready low 3 cycles at row 3 of set 0
  task automatic fill_rdy(input int mode, input int k);
    for (int i = 0; i < 1024; i++) begin
      rdy[i] = (mode == 1 && i < 900) ? ($urandom_range(3) != 0) : 1'b1;
    end
    if (mode == 2) begin
      for (int i = 0; i < 3; i++) rdy[k + 2 * A + 3 + i] = 1'b0;
    end
  endtask

  // Entry n = outputs expected right after the n-th edge, edge 0 being the one that takes start
  task automatic build(input int nsets, input int k);
    rec_t r;
    bit   strobe;
    exp_q.delete();
    if (nsets > 0) begin
      for (int s = 0; s < nsets; s++) begin
        r = idle_rec(); r.busy = 1;
        exp_q.push_back(r);
        for (int st = 0; st < k; st++) begin
          r = idle_rec(); r.busy = 1; r.alu = 1; r.cyc = st; r.raddr = s * K + st;
          exp_q.push_back(r);
        end
        for (int d = 0; d < 2 * A - 1; d++) begin
          r = idle_rec(); r.busy = 1; r.alu = 1; r.cyc = k + d;
          exp_q.push_back(r);
        end
        for (int row = 0; row < A; row++) begin
          do begin
            strobe = rdy[exp_q.size()];
            r = idle_rec(); r.busy = 1; r.midx = row;
            r.waddr = (s / NB) * A + row;
            r.we = strobe ? (1 << (s % NB)) : 0;
            exp_q.push_back(r);
          end while (!strobe);
        end
      end
    end
    r = idle_rec(); r.busy = 1; r.done = 1;
    exp_q.push_back(r);
    exp_q.push_back(idle_rec());
  endtask

  task automatic run(input string tag, input int nsets, input int k, input int mode,
                     input int abort_at, input int srst_at, input int glitch_at);
    rec_t r;
    fill_rdy(mode, k);
    build(nsets, k);
    for (int e = 0; e < exp_q.size(); e++) begin
      @(negedge clk);
      start     = (e == 0) || (e == glitch_at);
      abort     = (e == abort_at);
      srst      = (e == srst_at);
      out_ready = rdy[e];
      if (e == 0) begin
        cfg_data_sets = 3'(nsets);
        cfg_k_steps   = 5'(k);
      end else begin
        cfg_data_sets = 3'($urandom_range(MS));
        cfg_k_steps   = 5'($urandom_range(K, 1));
      end
      @(posedge clk);
      #1;
      r = (e == abort_at || e == srst_at) ? idle_rec() : exp_q[e];
      check_outputs(tag, e, r);
      if (e == abort_at || e == srst_at) break;
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; srst = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    int ns, kk;
    srst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    cfg_data_sets = '0; cfg_k_steps = 5'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outputs("reset", i, idle_rec());
    end
    @(negedge clk);
    srst = 1'b0;

    run("basic",   1, 24, 0, NONE, NONE, NONE);
    run("foursets", 4, 24, 0, NONE, NONE, NONE);
    run("stall",   1, 24, 2, NONE, NONE, NONE);
    run("abort",   2, 10, 0, 1 + 10 + 4, NONE, NONE);
    run("postabort", 1, 5, 0, NONE, NONE, NONE);
    run("zerosets", 0, 7, 0, NONE, NONE, NONE);
    run("glitch",  2, 7, 1, NONE, NONE, 1 + 3);
    run("srst",    3, 24, 0, NONE, 10, NONE);
    run("postsrst", 1, 24, 0, NONE, NONE, NONE);
    for (int i = 0; i < 8; i++) begin
      ns = $urandom_range(MS);
      kk = $urandom_range(K, 1);
      run("random", ns, kk, 1, NONE, NONE, NONE);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tpu_tile_sequencer.md
TPU_TILE_SEQUENCER -- requirements
Module: tpu_tile_sequencer

Interface
REQ-001 Parameters, each as name, default, meaning:
- ARRAY_SIZE, 8, systolic rows/cols.
- K_ACCUM_DEPTH, 24, maximum accumulation steps.
- NUM_BANKS, 3, output SRAM banks.
- MAX_DATA_SET, 4, maximum data sets per run.
- RADDR_WIDTH, 10.
- WADDR_WIDTH, 6.
REQ-002 clk  in  1  sole clock; all logic rising-edge.
REQ-003 srst  in  1  reset; synchronous and active-high.
REQ-004 start  in  1  run request pulse.
REQ-005 abort  in  1  synchronous run cancel.
REQ-006 cfg_data_sets  in  clog2(MAX_DATA_SET+1)  data-set count, sampled on accepted start.
REQ-007 cfg_k_steps  in  clog2(K_ACCUM_DEPTH+1)  accumulation steps per set, range 1..K_ACCUM_DEPTH, sampled on accepted start.
REQ-008 out_ready  in  1  write-side ready.
REQ-009 sram_raddr_w / sram_raddr_d  out  RADDR_WIDTH  weight/data read addresses.
REQ-010 alu_start  out  1  systolic enable.
REQ-011 cycle_num  out  clog2(K_ACCUM_DEPTH+2*ARRAY_SIZE)  systolic step count.
REQ-012 matrix_index  out  clog2(ARRAY_SIZE)  output row being written.
REQ-013 sram_write_enable  out  NUM_BANKS  one-hot bank write strobe.
REQ-014 sram_waddr  out  WADDR_WIDTH  bank write address.
REQ-015 busy  out  1  run in progress.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, LOAD, DRAIN, WRITE, DONE.
REQ-018 start SHALL be accepted only in IDLE; start in any other state SHALL be ignored.
REQ-019 An accepted start with cfg_data_sets==0 SHALL go to DONE with no strobes.
REQ-020 Otherwise an accepted start SHALL go to CLEAR, with set index = 0.
REQ-021 CLEAR SHALL last 1 cycle with alu_start=0 and cycle_num=0, then go to LOAD.
REQ-022 LOAD SHALL last cfg_k_steps cycles.
- sram_raddr_w and sram_raddr_d SHALL both equal set*K_ACCUM_DEPTH + step, with step 0..cfg_k_steps-1.
REQ-023 DRAIN SHALL last 2*ARRAY_SIZE-1 cycles.
REQ-024 alu_start SHALL be 1 throughout LOAD and DRAIN.
REQ-025 cycle_num SHALL start at 0 on the first LOAD cycle and increment by 1 each LOAD/DRAIN cycle.
REQ-026 In WRITE, sram_write_enable[bank] SHALL equal out_ready, where bank = set mod NUM_BANKS; all other bits SHALL be 0.
REQ-027 In WRITE, sram_waddr SHALL equal (set div NUM_BANKS)*ARRAY_SIZE + matrix_index.
- bank and pass SHALL be held in wrap counters; no divider.
REQ-028 matrix_index SHALL advance only on cycles with out_ready=1.
- While out_ready=0, matrix_index and sram_waddr SHALL hold.
REQ-029 After the row ARRAY_SIZE-1 write completes, the FSM SHALL go to DONE if set==cfg_data_sets-1; otherwise it SHALL increment set and go to CLEAR.
REQ-030 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 abort in any non-IDLE state SHALL force IDLE on the next edge, with all outputs at reset values and no done pulse.
REQ-033 Priority SHALL be srst > abort > start.
REQ-034 All outputs SHALL be registered, with no combinational input-to-output path.

Reset
REQ-035 On srst, state SHALL be IDLE and every output SHALL be 0, including sram_write_enable=0 and done=0.
REQ-036 srst asserted mid-run SHALL discard the captured configuration and produce no done pulse.

Structure
REQ-037 The state enum and the derived widths (cycle_num, matrix_index, set counter) SHALL reside in the shared package tpu_pkg.
REQ-038 The block SHALL be a single module with no sub-module; the bank/pass wrap counters SHALL be inline.

Verification
REQ-039 Scenario: ARRAY_SIZE=8, K=24, NUM_BANKS=3, cfg_data_sets=1, cfg_k_steps=24, out_ready=1, start at edge T -> required response:
- CLEAR at T+1.
- LOAD T+2..T+25, raddr 0..23.
- DRAIN T+26..T+40.
- WRITE T+41..T+48, bank 0, waddr 0..7.
- done=1 at T+49.
REQ-040 Scenario: cfg_data_sets=4 -> write banks 0,1,2,0; the 4th set writes waddr 8..15; the 4th set's LOAD raddr starts at 72.
REQ-041 Scenario: out_ready=0 for 3 cycles at matrix_index=3 -> no strobes, index holds at 3, done delayed exactly 3 cycles.
REQ-042 Scenario: abort on the 5th DRAIN cycle -> next cycle IDLE, busy=0, alu_start=0, no done; a following start completes normally.
REQ-043 Scenario: cfg_data_sets=0 start -> done the following cycle, no strobes; start pulsed mid-LOAD of a run -> ignored, with no change in timing.
REQ-044 Scenario: srst at the 10th LOAD cycle -> all outputs 0 the next cycle; a subsequent start produces the REQ-039 timing.
